// File: rtl/qlearn_action_select.sv
// ============================================================================
// Module   : qlearn_action_select
// Brief    : Epsilon-greedy action selector feeding the Q-update pipeline.
//            Optional QSEL_STATS_EN adds step and explore counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qlearn_action_select #(
    parameter int                     STATE_WIDTH  = 6,
    parameter int                     ACTION_WIDTH = 2,
    parameter int                     DATA_WIDTH   = 8,
    parameter logic [STATE_WIDTH-1:0] START_STATE  = '0,
    parameter logic [15:0]            LFSR_SEED    = 16'hACE1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [7:0]                           i_epsilon,
    input  logic [STATE_WIDTH-1:0]               i_end_state,
    output logic [STATE_WIDTH+ACTION_WIDTH-1:0]  o_q_addr,
    output logic                                 o_q_rd,
    input  logic [DATA_WIDTH-1:0]                i_q_data,
    output logic                                 o_sa_valid,
    input  logic                                 i_sa_ready,
    output logic [STATE_WIDTH-1:0]               o_state,
    output logic [ACTION_WIDTH-1:0]              o_action,
    input  logic                                 i_next_valid,
    input  logic [STATE_WIDTH-1:0]               i_next_state,
    output logic                                 o_busy,
`ifdef QSEL_STATS_EN
    output logic [15:0]                          o_step_count,
    output logic [15:0]                          o_explore_count,
`endif
    output logic                                 o_episode_done
);

    localparam logic [15:0]           c_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [ACTION_WIDTH:0] c_SCAN_LAST = {1'b1, {ACTION_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_SCAN  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   r_fsm;
    state_t                   w_fsm_nxt;
    logic [15:0]              r_lfsr;
    logic [STATE_WIDTH-1:0]   r_state;
    logic [ACTION_WIDTH-1:0]  r_action;
    logic                     r_sa_valid;
    logic [ACTION_WIDTH:0]    r_scan_cnt;
    logic                     r_rd_pend;
    logic [ACTION_WIDTH-1:0]  r_rd_idx;
    logic [DATA_WIDTH-1:0]    r_best;

    logic                     w_explore;
    logic                     w_rd;
    logic                     w_scan_last;
    logic                     w_xfer;
    logic [15:0]              w_lfsr_nxt;

    assign w_explore   = (r_lfsr[7:0] < i_epsilon);
    assign w_rd        = (r_fsm == S_SCAN) && !r_scan_cnt[ACTION_WIDTH];
    assign w_scan_last = (r_fsm == S_SCAN) && (r_scan_cnt == c_SCAN_LAST);
    assign w_xfer      = r_sa_valid && i_sa_ready;
    assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign o_q_rd         = w_rd;
    assign o_q_addr       = w_rd ? {r_state, r_scan_cnt[ACTION_WIDTH-1:0]} : '0;
    assign o_sa_valid     = r_sa_valid;
    assign o_state        = r_state;
    assign o_action       = r_action;
    assign o_busy         = (r_fsm != S_IDLE);
    assign o_episode_done = (r_fsm == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (i_start) w_fsm_nxt = S_DRAW;
            S_DRAW:  w_fsm_nxt = w_explore ? S_ISSUE : S_SCAN;
            S_SCAN:  if (w_scan_last) w_fsm_nxt = S_ISSUE;
            S_ISSUE: if (w_xfer) w_fsm_nxt = S_WAIT;
            S_WAIT: begin
                if (i_next_valid) begin
                    w_fsm_nxt = (i_next_state == i_end_state) ? S_DONE : S_DRAW;
                end
            end
            S_DONE:  w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr     <= c_SEED;
            r_state    <= '0;
            r_action   <= '0;
            r_sa_valid <= 1'b0;
            r_scan_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_idx   <= '0;
            r_best     <= '0;
        end else begin
            r_rd_pend <= w_rd;
            r_rd_idx  <= r_scan_cnt[ACTION_WIDTH-1:0];
            case (r_fsm)
                S_IDLE: if (i_start) r_state <= START_STATE;
                S_DRAW: begin
                    r_lfsr     <= w_lfsr_nxt;
                    r_scan_cnt <= '0;
                    if (w_explore) r_action <= r_lfsr[8 +: ACTION_WIDTH];
                end
                S_SCAN: r_scan_cnt <= r_scan_cnt + 1'b1;
                // Valid rises one cycle after entering ISSUE, drops the cycle after transfer.
                S_ISSUE: begin
                    if (!r_sa_valid) r_sa_valid <= 1'b1;
                    else if (i_sa_ready) r_sa_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (i_next_valid && (i_next_state != i_end_state)) r_state <= i_next_state;
                end
                default: ;
            endcase
            // First returned value seeds the max; strictly-greater keeps the lowest action on ties.
            if (r_rd_pend && ((r_rd_idx == '0) || (i_q_data > r_best))) begin
                r_best   <= i_q_data;
                r_action <= r_rd_idx;
            end
        end
    end

`ifdef QSEL_STATS_EN
    logic [15:0] r_step_cnt;
    logic [15:0] r_expl_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_step_cnt <= '0;
            r_expl_cnt <= '0;
        end else if ((r_fsm == S_IDLE) && i_start) begin
            r_step_cnt <= '0;
            r_expl_cnt <= '0;
        end else begin
            if (w_xfer && (r_step_cnt != 16'hFFFF)) r_step_cnt <= r_step_cnt + 16'd1;
            if ((r_fsm == S_DRAW) && w_explore && (r_expl_cnt != 16'hFFFF)) begin
                r_expl_cnt <= r_expl_cnt + 16'd1;
            end
        end
    end

    assign o_step_count    = r_step_cnt;
    assign o_explore_count = r_expl_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qlearn_action_select.sv
// ============================================================================
// Module   : tb_qlearn_action_select
// Brief    : Randomized self-checking bench against an episode-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qlearn_action_select;

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_epsilon;
    logic [5:0] i_end_state;
    logic [7:0] o_q_addr;
    logic       o_q_rd;
    logic [7:0] i_q_data;
    logic       o_sa_valid;
    logic       i_sa_ready;
    logic [5:0] o_state;
    logic [1:0] o_action;
    logic       i_next_valid;
    logic [5:0] i_next_state;
    logic       o_busy;
    logic       o_episode_done;
`ifdef QSEL_STATS_EN
    logic [15:0] o_step_count;
    logic [15:0] o_explore_count;
`endif

    qlearn_action_select u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_epsilon      (i_epsilon),
        .i_end_state    (i_end_state),
        .o_q_addr       (o_q_addr),
        .o_q_rd         (o_q_rd),
        .i_q_data       (i_q_data),
        .o_sa_valid     (o_sa_valid),
        .i_sa_ready     (i_sa_ready),
        .o_state        (o_state),
        .o_action       (o_action),
        .i_next_valid   (i_next_valid),
        .i_next_state   (i_next_state),
        .o_busy         (o_busy),
`ifdef QSEL_STATS_EN
        .o_step_count   (o_step_count),
        .o_explore_count(o_explore_count),
`endif
        .o_episode_done (o_episode_done)
    );

    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [7:0]  qmem [256];
    logic [7:0]  rdq [$];
    logic [15:0] m_lfsr;
    int          m_steps;
    int          m_expl;
    logic        pend_v = 1'b0;
    logic [7:0]  pend_a = 8'd0;

    always @(posedge i_clk) cyc++;

    // Q-table model: one-cycle read latency, garbage when nothing is outstanding.
    always @(negedge i_clk) begin
        i_q_data = pend_v ? qmem[pend_a] : 8'($urandom);
        pend_v   = o_q_rd && !i_rst;
        pend_a   = o_q_addr;
        if (o_q_rd) rdq.push_back(o_q_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [1:0] greedy(input logic [5:0] st);
        int         best = -1;
        logic [1:0] ba   = 2'd0;
        for (int a = 0; a < 4; a++) begin
            if (int'(qmem[{st, a[1:0]}]) > best) begin
                best = int'(qmem[{st, a[1:0]}]);
                ba   = a[1:0];
            end
        end
        return ba;
    endfunction

    task automatic check_stats();
`ifdef QSEL_STATS_EN
        check("step_count", 32'(o_step_count), 32'(m_steps));
        check("explore_count", 32'(o_explore_count), 32'(m_expl));
`endif
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst    = 1'b0;
        m_lfsr   = c_SEED;
        m_steps  = 0;
        m_expl   = 0;
    endtask

    task automatic run_episode(input logic [7:0] eps, input int n_steps, input logic [5:0] end_st,
                               input int fnext, input int fdelay);
        logic [5:0] cur;
        logic [5:0] nxt;
        logic       expl;
        logic [1:0] act;
        int         trig;
        int         k;
        int         d;
        i_epsilon   = eps;
        i_end_state = end_st;
        rdq.delete();
        i_start = 1'b1;
        trig    = cyc + 1;
        @(negedge i_clk);
        i_start = 1'b0;
        cur     = 6'd0;
        m_steps = 0;
        m_expl  = 0;
        for (int s = 0; s < n_steps; s++) begin
            expl = (m_lfsr[7:0] < eps);
            act  = expl ? m_lfsr[9:8] : greedy(cur);
            if (expl) m_expl++;
            m_lfsr = lfsr_next(m_lfsr);
            k = 0;
            while (!o_sa_valid && k < 20) begin
                i_next_valid = 1'($urandom_range(0, 1));
                i_next_state = 6'($urandom);
                i_start      = 1'($urandom_range(0, 1));
                @(negedge i_clk);
                k++;
            end
            i_next_valid = 1'b0;
            i_start      = 1'b0;
            if (!o_sa_valid) begin
                check("valid_timeout", 32'(o_sa_valid), 32'd1);
                apply_reset();
                return;
            end
            check("latency", 32'(cyc - trig), expl ? 32'd2 : 32'd7);
            check("state", 32'(o_state), 32'(cur));
            check("action", 32'(o_action), 32'(act));
            check("rd_count", 32'(rdq.size()), expl ? 32'd0 : 32'd4);
            if (!expl && rdq.size() == 4) begin
                for (int a = 0; a < 4; a++) check("q_addr", 32'(rdq[a]), 32'({cur, a[1:0]}));
            end
            d = (fdelay >= 0) ? fdelay : $urandom_range(0, 6);
            repeat (d) begin
                @(negedge i_clk);
                check("hold_valid", 32'(o_sa_valid), 32'd1);
                check("hold_state", 32'(o_state), 32'(cur));
                check("hold_action", 32'(o_action), 32'(act));
            end
            i_sa_ready = 1'b1;
            @(negedge i_clk);
            i_sa_ready = 1'b0;
            m_steps++;
            check("valid_drop", 32'(o_sa_valid), 32'd0);
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            check("busy_wait", 32'(o_busy), 32'd1);
            if (s == n_steps - 1) begin
                nxt = end_st;
            end else if (fnext >= 0) begin
                nxt = 6'(fnext);
            end else begin
                nxt = 6'($urandom);
                while (nxt == end_st) nxt = 6'($urandom);
            end
            rdq.delete();
            i_next_state = nxt;
            i_next_valid = 1'b1;
            trig = cyc + 1;
            @(negedge i_clk);
            i_next_valid = 1'b0;
            cur = nxt;
        end
        check("done_pulse", 32'(o_episode_done), 32'd1);
        @(negedge i_clk);
        check("done_clear", 32'(o_episode_done), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check_stats();
    endtask

    task automatic reset_mid_scan();
        int k = 0;
        i_epsilon   = 8'd0;
        i_end_state = 6'd63;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (!o_q_rd && k < 10) begin
            @(negedge i_clk);
            k++;
        end
        check("rd_seen", 32'(o_q_rd), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check("rst_rd", 32'(o_q_rd), 32'd0);
        check("rst_valid", 32'(o_sa_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_addr", 32'(o_q_addr), 32'd0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        m_lfsr  = c_SEED;
        m_steps = 0;
        m_expl  = 0;
        check_stats();
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_epsilon    = 8'd0;
        i_end_state  = 6'd0;
        i_sa_ready   = 1'b0;
        i_next_valid = 1'b0;
        i_next_state = 6'd0;
        i_q_data     = 8'd0;
        for (int i = 0; i < 256; i++) qmem[i] = 8'($urandom);
        m_lfsr  = c_SEED;
        m_steps = 0;
        m_expl  = 0;
        repeat (2) @(negedge i_clk);
        check("rst_busy0", 32'(o_busy), 32'd0);
        check("rst_valid0", 32'(o_sa_valid), 32'd0);
        check("rst_rd0", 32'(o_q_rd), 32'd0);
        check("rst_done0", 32'(o_episode_done), 32'd0);
        check("rst_state0", 32'(o_state), 32'd0);
        check("rst_action0", 32'(o_action), 32'd0);
        check_stats();
        i_rst = 1'b0;
        @(negedge i_clk);

        // Tie in row 0: actions 1 and 2 both hold 40, lowest must win.
        qmem[0] = 8'd10; qmem[1] = 8'd40; qmem[2] = 8'd40; qmem[3] = 8'd5;
        run_episode(8'd0, 1, 6'd63, -1, 5);
        run_episode(8'd0, 2, 6'd9, 3, 1);
        run_episode(8'd255, 3, 6'd9, -1, -1);
        reset_mid_scan();
        run_episode(8'd255, 3, 6'd40, -1, 0);

        for (int e = 0; e < 30; e++) begin
            logic [7:0] eps;
            int         sel;
            for (int i = 0; i < 256; i++) begin
                qmem[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end
            sel = $urandom_range(0, 3);
            eps = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
            run_episode(eps, $urandom_range(1, 5), 6'($urandom), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
